// File: rtl/coredma_ram_cache_ecc_if.sv
// Bus bundle for the SECDED cache RAM: one write port, one read port,
// error flags and the status counters read by the CoreDMA controller.
interface coredma_ram_cache_ecc_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 7
);
  logic                  WEN;
  logic [ADDR_WIDTH-1:0] WADDR;
  logic [DATA_WIDTH-1:0] WDATA;
  logic [1:0]            INJ_ERR;
  logic                  REN;
  logic [ADDR_WIDTH-1:0] RADDR;
  logic                  CNT_CLR;
  logic [DATA_WIDTH-1:0] RDATA;
  logic                  RVALID;
  logic                  SB_CORRECT;
  logic                  DB_DETECT;
  logic [ADDR_WIDTH-1:0] ERR_ADDR;
  logic [15:0]           SB_COUNT;
  logic [15:0]           DB_COUNT;

  // No back-pressure: WEN and REN are accepted on every edge they are high.
  // RVALID pulses once per accepted read, two edges later, and qualifies
  // RDATA, SB_CORRECT and DB_DETECT; the flags are 0 whenever RVALID is 0.
  modport master (
    output WEN, WADDR, WDATA, INJ_ERR, REN, RADDR, CNT_CLR,
    input  RDATA, RVALID, SB_CORRECT, DB_DETECT, ERR_ADDR, SB_COUNT, DB_COUNT
  );

  modport slave (
    input  WEN, WADDR, WDATA, INJ_ERR, REN, RADDR, CNT_CLR,
    output RDATA, RVALID, SB_CORRECT, DB_DETECT, ERR_ADDR, SB_COUNT, DB_COUNT
  );
endinterface

// File: rtl/coredma_ram_cache_ecc.sv
// SECDED-protected simple dual-port cache RAM with a corrected read pipeline,
// optional scrub of single-bit errors and saturating error statistics.
module coredma_ram_cache_ecc #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 7,
  parameter bit ECC_EN     = 1'b1,
  parameter bit SCRUB_EN   = 1'b1
) (
  input logic                    CLOCK,
  input logic                    RESET,
  coredma_ram_cache_ecc_if.slave bus
);

  function automatic int f_chk_bits(input int dw);
    int r;
    r = 0;
    for (int i = 1; i < 16; i++)
      if (r == 0 && (1 << i) >= dw + i + 1) r = i;
    return r;
  endfunction

  localparam int R     = f_chk_bits(DATA_WIDTH);
  localparam int CW    = DATA_WIDTH + R + 1;
  localparam int MEM_W = ECC_EN ? CW : DATA_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Codeword layout: bit 0 is overall parity, bits 1..CW-1 are Hamming
  // positions with check bits at the powers of two.
  function automatic logic [R-1:0] f_syndrome(input logic [CW-1:0] c);
    logic [R-1:0] s;
    s = '0;
    for (int p = 1; p < CW; p++)
      for (int i = 0; i < R; i++)
        if (((p >> i) & 1) == 1) s[i] = s[i] ^ c[p];
    return s;
  endfunction

  function automatic logic [CW-1:0] f_encode(input logic [DATA_WIDTH-1:0] d);
    logic [CW-1:0] c;
    logic [R-1:0]  s;
    int            k;
    c = '0;
    k = 0;
    for (int p = 3; p < CW; p++)
      if ((p & (p - 1)) != 0) begin
        c[p] = d[k];
        k++;
      end
    s = f_syndrome(c);
    for (int i = 0; i < R; i++) c[1 << i] = s[i];
    c[0] = ^c[CW-1:1];
    return c;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_extract(input logic [CW-1:0] c);
    logic [DATA_WIDTH-1:0] d;
    int                    k;
    d = '0;
    k = 0;
    for (int p = 3; p < CW; p++)
      if ((p & (p - 1)) != 0) begin
        d[k] = c[p];
        k++;
      end
    return d;
  endfunction

  logic [MEM_W-1:0]      r_mem [DEPTH];
  logic [MEM_W-1:0]      r_s1_word;
  logic                  r_s1_valid;
  logic [ADDR_WIDTH-1:0] r_s1_addr;
  logic                  r_s1_hit;
  logic [MEM_W-1:0]      r_s2_word;
  logic [R-1:0]          r_s2_syn;
  logic                  r_s2_perr;
  logic                  r_s2_valid;
  logic [ADDR_WIDTH-1:0] r_s2_addr;
  logic                  r_s2_hit;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;
  logic                  r_sb;
  logic                  r_db;
  logic [ADDR_WIDTH-1:0] r_err_addr;
  logic [15:0]           r_sb_cnt;
  logic [15:0]           r_db_cnt;
  logic                  r_scrub;
  logic [ADDR_WIDTH-1:0] r_scrub_addr;

  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_enc_in;
  logic [MEM_W-1:0]      w_wr_word;
  logic [R-1:0]          w_s1_syn;
  logic                  w_s1_perr;
  logic [DATA_WIDTH-1:0] w_s2_data;
  logic                  w_s2_sb;
  logic                  w_s2_db;
  logic                  w_s2_flag;
  logic                  w_late_hit;

  // A user write always owns the write port; a pending scrub only fills idle slots.
  assign w_mem_we   = bus.WEN || r_scrub;
  assign w_mem_addr = bus.WEN ? bus.WADDR : r_scrub_addr;
  assign w_enc_in   = bus.WEN ? bus.WDATA : r_rdata;

  generate
    if (ECC_EN) begin : g_ecc
      logic [CW-1:0] w_code;
      logic [CW-1:0] w_fix;

      always_comb begin
        w_code = f_encode(w_enc_in);
        if (bus.WEN && bus.INJ_ERR == 2'b01) w_code[0] = ~w_code[0];
        else if (bus.WEN && bus.INJ_ERR == 2'b10) w_code[1:0] = ~w_code[1:0];
      end

      // A parity error with syndrome 0 points at the parity bit itself.
      always_comb begin
        w_fix = r_s2_word;
        for (int p = 0; p < CW; p++)
          if (r_s2_perr && r_s2_syn == p[R-1:0]) w_fix[p] = ~r_s2_word[p];
      end

      assign w_wr_word = w_code;
      assign w_s1_syn  = f_syndrome(r_s1_word);
      assign w_s1_perr = ^r_s1_word;
      assign w_s2_data = f_extract(w_fix);
      assign w_s2_sb   = r_s2_perr;
      assign w_s2_db   = !r_s2_perr && (r_s2_syn != '0);
    end else begin : g_raw
      assign w_wr_word = w_enc_in;
      assign w_s1_syn  = '0;
      assign w_s1_perr = 1'b0;
      assign w_s2_data = r_s2_word;
      assign w_s2_sb   = 1'b0;
      assign w_s2_db   = 1'b0;
    end
  endgenerate

  assign w_s2_flag  = r_s2_valid && (w_s2_sb || w_s2_db);
  assign w_late_hit = bus.WEN && (bus.WADDR == r_s2_addr);

  // Array and its registered read port; non-blocking update gives read-first.
  always_ff @(posedge CLOCK) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_wr_word;
    if (bus.REN) r_s1_word <= r_mem[bus.RADDR];
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_s1_valid   <= 1'b0;
      r_s1_addr    <= '0;
      r_s1_hit     <= 1'b0;
      r_s2_word    <= '0;
      r_s2_syn     <= '0;
      r_s2_perr    <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_s2_addr    <= '0;
      r_s2_hit     <= 1'b0;
      r_rdata      <= '0;
      r_rvalid     <= 1'b0;
      r_sb         <= 1'b0;
      r_db         <= 1'b0;
      r_err_addr   <= '0;
      r_sb_cnt     <= '0;
      r_db_cnt     <= '0;
      r_scrub      <= 1'b0;
      r_scrub_addr <= '0;
    end else begin
      r_s1_valid <= bus.REN;
      r_s1_addr  <= bus.RADDR;
      r_s1_hit   <= bus.WEN && (bus.WADDR == bus.RADDR);

      r_s2_word  <= r_s1_word;
      r_s2_syn   <= w_s1_syn;
      r_s2_perr  <= w_s1_perr;
      r_s2_valid <= r_s1_valid;
      r_s2_addr  <= r_s1_addr;
      r_s2_hit   <= r_s1_hit || (bus.WEN && (bus.WADDR == r_s1_addr));

      r_rvalid <= r_s2_valid;
      r_sb     <= r_s2_valid && w_s2_sb;
      r_db     <= r_s2_valid && w_s2_db;
      if (r_s2_valid) r_rdata <= w_s2_data;

      // Any user write to this address since the array read holds newer data.
      r_scrub      <= ECC_EN && SCRUB_EN && r_s2_valid && w_s2_sb &&
                      !r_s2_hit && !w_late_hit;
      r_scrub_addr <= r_s2_addr;

      if (bus.CNT_CLR) begin
        r_sb_cnt   <= '0;
        r_db_cnt   <= '0;
        r_err_addr <= '0;
      end else begin
        if (w_s2_flag) r_err_addr <= r_s2_addr;
        if (r_s2_valid && w_s2_sb && r_sb_cnt != 16'hFFFF) r_sb_cnt <= r_sb_cnt + 16'd1;
        if (r_s2_valid && w_s2_db && r_db_cnt != 16'hFFFF) r_db_cnt <= r_db_cnt + 16'd1;
      end
    end
  end

  assign bus.RDATA      = r_rdata;
  assign bus.RVALID     = r_rvalid;
  assign bus.SB_CORRECT = r_sb;
  assign bus.DB_DETECT  = r_db;
  assign bus.ERR_ADDR   = r_err_addr;
  assign bus.SB_COUNT   = r_sb_cnt;
  assign bus.DB_COUNT   = r_db_cnt;

endmodule

// File: tb/tb_coredma_ram_cache_ecc.sv
// Directed bench for coredma_ram_cache_ecc: vector table of write/read pairs
// plus hand sequences for scrub hazards, reset mid-read and counter saturation.
module tb_coredma_ram_cache_ecc;
  localparam int DW = 128;
  localparam int AW = 7;

  localparam logic [DW-1:0] D_CLEAN = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [DW-1:0] D_A5    = {16{8'hA5}};
  localparam logic [DW-1:0] D_FH    = 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000;
  localparam logic [DW-1:0] D_BEEF  = 128'hDEAD_BEEF_0BAD_F00D_1234_5678_9ABC_DEF0;
  localparam logic [DW-1:0] D_55    = {16{8'h55}};
  localparam logic [DW-1:0] D_CAFE  = 128'hCAFE_BABE_0000_1111_2222_3333_4444_5555;
  localparam logic [DW-1:0] D_NEW   = 128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  coredma_ram_cache_ecc_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  coredma_ram_cache_ecc #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ECC_EN(1'b1), .SCRUB_EN(1'b1)
  ) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no end of test, required end before 1000000");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic          do_wr;
    logic [1:0]    inj;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_data;
    logic          exp_sb;
    logic          exp_db;
    logic [AW-1:0] exp_err;
    logic [15:0]   exp_sbc;
    logic [15:0]   exp_dbc;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic rv, input logic [DW-1:0] d,
                         input logic sb, input logic db, input logic [AW-1:0] ea,
                         input logic [15:0] sc, input logic [15:0] dc);
    chk({tag, ".rvalid"}, DW'(bus.RVALID), DW'(rv));
    chk({tag, ".rdata"}, bus.RDATA, d);
    chk({tag, ".sb"}, DW'(bus.SB_CORRECT), DW'(sb));
    chk({tag, ".db"}, DW'(bus.DB_DETECT), DW'(db));
    chk({tag, ".err_addr"}, DW'(bus.ERR_ADDR), DW'(ea));
    chk({tag, ".sb_count"}, DW'(bus.SB_COUNT), DW'(sc));
    chk({tag, ".db_count"}, DW'(bus.DB_COUNT), DW'(dc));
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] inj);
    bus.WEN = 1'b1; bus.WADDR = a; bus.WDATA = d; bus.INJ_ERR = inj;
    tick();
    bus.WEN = 1'b0; bus.INJ_ERR = 2'b00;
  endtask

  // REN at edge N, result checked after N+2, then an idle edge N+3 (scrub slot).
  task automatic read_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic sb, input logic db, input logic [AW-1:0] ea,
                          input logic [15:0] sc, input logic [15:0] dc);
    bus.REN = 1'b1; bus.RADDR = a;
    tick();
    bus.REN = 1'b0;
    tick();
    chk({tag, ".early_rvalid"}, DW'(bus.RVALID), '0);
    tick();
    chk_out(tag, 1'b1, d, sb, db, ea, sc, dc);
    tick();
    chk({tag, ".idle_rvalid"}, DW'(bus.RVALID), '0);
    chk({tag, ".idle_flags"}, DW'({bus.SB_CORRECT, bus.DB_DETECT}), '0);
  endtask

  initial begin
    bus.WEN = 1'b0; bus.WADDR = '0; bus.WDATA = '0; bus.INJ_ERR = 2'b00;
    bus.REN = 1'b0; bus.RADDR = '0; bus.CNT_CLR = 1'b0;

    //           wr    inj    addr    wdata    exp_data sb    db    err     sbc    dbc
    vecs[0] = '{1'b1, 2'b00, 7'd5,   D_CLEAN, D_CLEAN, 1'b0, 1'b0, 7'd0,   16'd0, 16'd0};
    vecs[1] = '{1'b1, 2'b01, 7'd9,   D_A5,    D_A5,    1'b1, 1'b0, 7'd9,   16'd1, 16'd0};
    vecs[2] = '{1'b0, 2'b00, 7'd9,   '0,      D_A5,    1'b0, 1'b0, 7'd9,   16'd1, 16'd0};
    vecs[3] = '{1'b1, 2'b10, 7'd3,   D_FH,    D_FH,    1'b0, 1'b1, 7'd3,   16'd1, 16'd1};
    vecs[4] = '{1'b0, 2'b00, 7'd3,   '0,      D_FH,    1'b0, 1'b1, 7'd3,   16'd1, 16'd2};
    vecs[5] = '{1'b1, 2'b11, 7'd20,  D_BEEF,  D_BEEF,  1'b0, 1'b0, 7'd3,   16'd1, 16'd2};
    vecs[6] = '{1'b1, 2'b01, 7'd127, D_55,    D_55,    1'b1, 1'b0, 7'd127, 16'd2, 16'd2};
    vecs[7] = '{1'b0, 2'b00, 7'd127, '0,      D_55,    1'b0, 1'b0, 7'd127, 16'd2, 16'd2};
    vecs[8] = '{1'b1, 2'b10, 7'd0,   '0,      '0,      1'b0, 1'b1, 7'd0,   16'd2, 16'd3};
    vecs[9] = '{1'b0, 2'b00, 7'd5,   '0,      D_CLEAN, 1'b0, 1'b0, 7'd0,   16'd2, 16'd3};

    repeat (3) tick();
    chk_out("reset", 1'b0, '0, 1'b0, 1'b0, '0, 16'd0, 16'd0);
    RESET = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_wr) do_write(vecs[i].addr, vecs[i].wdata, vecs[i].inj);
      read_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_data, vecs[i].exp_sb,
               vecs[i].exp_db, vecs[i].exp_err, vecs[i].exp_sbc, vecs[i].exp_dbc);
    end

    // Back-to-back reads on consecutive edges.
    bus.REN = 1'b1; bus.RADDR = 7'd5;
    tick();
    bus.RADDR = 7'd9;
    tick();
    bus.REN = 1'b0;
    tick();
    chk_out("b2b0", 1'b1, D_CLEAN, 1'b0, 1'b0, 7'd0, 16'd2, 16'd3);
    tick();
    chk_out("b2b1", 1'b1, D_A5, 1'b0, 1'b0, 7'd0, 16'd2, 16'd3);
    tick();
    chk("b2b.drop_rvalid", DW'(bus.RVALID), '0);

    // Read and write to the same address on the same edge return the old word.
    bus.WEN = 1'b1; bus.WADDR = 7'd20; bus.WDATA = D_NEW;
    bus.REN = 1'b1; bus.RADDR = 7'd20;
    tick();
    bus.WEN = 1'b0; bus.REN = 1'b0;
    tick();
    tick();
    chk_out("rdfirst", 1'b1, D_BEEF, 1'b0, 1'b0, 7'd0, 16'd2, 16'd3);
    tick();
    read_chk("rdfirst.new", 7'd20, D_NEW, 1'b0, 1'b0, 7'd0, 16'd2, 16'd3);

    // User write lands while the erroneous read is in flight: scrub must not overwrite it.
    do_write(7'd7, D_CAFE, 2'b01);
    bus.REN = 1'b1; bus.RADDR = 7'd7;
    tick();
    bus.REN = 1'b0;
    bus.WEN = 1'b1; bus.WADDR = 7'd7; bus.WDATA = 128'h1;
    tick();
    bus.WEN = 1'b0;
    tick();
    chk_out("hazard", 1'b1, D_CAFE, 1'b1, 1'b0, 7'd7, 16'd3, 16'd3);
    tick();
    read_chk("hazard.after", 7'd7, 128'h1, 1'b0, 1'b0, 7'd7, 16'd3, 16'd3);

    // User write in the scrub slot wins; the scrub is dropped, not retried.
    do_write(7'd11, D_55, 2'b01);
    bus.REN = 1'b1; bus.RADDR = 7'd11;
    tick();
    bus.REN = 1'b0;
    tick();
    tick();
    chk_out("drop", 1'b1, D_55, 1'b1, 1'b0, 7'd11, 16'd4, 16'd3);
    bus.WEN = 1'b1; bus.WADDR = 7'd12; bus.WDATA = '0;
    tick();
    bus.WEN = 1'b0;
    read_chk("drop.reread", 7'd11, D_55, 1'b1, 1'b0, 7'd11, 16'd5, 16'd3);

    // Reset pulsed between N+1 and N+2 discards the in-flight read.
    bus.REN = 1'b1; bus.RADDR = 7'd5;
    tick();
    bus.REN = 1'b0;
    tick();
    RESET = 1'b1;
    #2;
    chk_out("midrst", 1'b0, '0, 1'b0, 1'b0, 7'd0, 16'd0, 16'd0);
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("midrst.rvalid%0d", i), DW'(bus.RVALID), '0);
    end
    read_chk("midrst.retained", 7'd5, D_CLEAN, 1'b0, 1'b0, 7'd0, 16'd0, 16'd0);

    // 65537 single-bit-error reads: every edge rewrites addr 0 with an injected
    // error, so each scrub loses to the user write.
    do_write(7'd0, D_A5, 2'b01);
    bus.WEN = 1'b1; bus.WADDR = 7'd0; bus.WDATA = D_A5; bus.INJ_ERR = 2'b01;
    bus.REN = 1'b1; bus.RADDR = 7'd0;
    for (int i = 0; i < 65537; i++) tick();
    bus.WEN = 1'b0; bus.REN = 1'b0; bus.INJ_ERR = 2'b00;
    repeat (3) tick();
    chk("sat.sb_count", DW'(bus.SB_COUNT), DW'(16'hFFFF));
    chk("sat.db_count", DW'(bus.DB_COUNT), '0);

    // CNT_CLR on the same edge as a flagged read wins over the increment.
    bus.REN = 1'b1; bus.RADDR = 7'd3;
    tick();
    bus.REN = 1'b0;
    tick();
    bus.CNT_CLR = 1'b1;
    tick();
    bus.CNT_CLR = 1'b0;
    chk_out("clr_prio", 1'b1, D_FH, 1'b0, 1'b1, 7'd0, 16'd0, 16'd0);
    tick();
    read_chk("clr.db", 7'd3, D_FH, 1'b0, 1'b1, 7'd3, 16'd0, 16'd1);
    bus.CNT_CLR = 1'b1;
    tick();
    bus.CNT_CLR = 1'b0;
    chk("clr.err_addr", DW'(bus.ERR_ADDR), '0);
    chk("clr.db_count", DW'(bus.DB_COUNT), '0);
    chk("clr.sb_count", DW'(bus.SB_COUNT), '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
